// File: rtl/bp_lce_req_buffer.sv
// bp_lce_req_buffer
// Egress buffer for LCE requests: a small FIFO whose head is launched onto the
// coherence NoC request link only while a NoC credit is held. Credits are
// consumed on each send and recovered from single-cycle return pulses.

module bp_lce_req_buffer #(
    parameter int unsigned msg_width_p = 128,
    parameter int unsigned els_p       = 2,
    parameter int unsigned credits_p   = 8,
    localparam int unsigned ptr_w_lp   = $clog2(els_p),
    localparam int unsigned occ_w_lp   = $clog2(els_p + 1),
    localparam int unsigned cred_w_lp  = $clog2(credits_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,

    input  logic [msg_width_p-1:0] lce_req_i,
    input  logic                   lce_req_v_i,
    output logic                   lce_req_ready_then_o,

    output logic [msg_width_p-1:0] lce_req_o,
    output logic                   lce_req_v_o,

    input  logic                   credit_return_i,
    output logic                   credits_full_o,
    output logic                   credits_empty_o,
    output logic [cred_w_lp-1:0]   credit_avail_o,
    output logic [occ_w_lp-1:0]    occupancy_o
);

    localparam logic [occ_w_lp-1:0]  occ_max_lp  = occ_w_lp'(els_p);
    localparam logic [cred_w_lp-1:0] cred_max_lp = cred_w_lp'(credits_p);
    localparam logic [ptr_w_lp-1:0]  ptr_one_lp  = ptr_w_lp'(1);
    localparam logic [occ_w_lp-1:0]  occ_one_lp  = occ_w_lp'(1);
    localparam logic [cred_w_lp-1:0] cred_one_lp = cred_w_lp'(1);

    logic [msg_width_p-1:0] mem_r [els_p];
    logic [ptr_w_lp-1:0]    wr_ptr_r;
    logic [ptr_w_lp-1:0]    rd_ptr_r;
    logic [occ_w_lp-1:0]    occ_r;
    logic [cred_w_lp-1:0]   avail_r;
    logic [cred_w_lp-1:0]   avail_next;
    logic                   enq;
    logic                   send;

    // Ready and send are decoded from registered state only, so the LCE never
    // sees a combinational path from the NoC side.
    assign lce_req_ready_then_o = (occ_r < occ_max_lp);
    assign enq                  = lce_req_v_i & lce_req_ready_then_o;
    assign send                 = (occ_r != '0) & (avail_r != '0);

    assign lce_req_v_o     = send;
    assign lce_req_o       = mem_r[rd_ptr_r];
    assign credits_full_o  = (avail_r == '0);
    assign credits_empty_o = (avail_r == cred_max_lp);
    assign credit_avail_o  = avail_r;
    assign occupancy_o     = occ_r;

    // Message storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wr_ptr_r] <= lce_req_i;
        end
    end

    // Read/write pointers wrap naturally because els_p is a power of two
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (enq) begin
                wr_ptr_r <= wr_ptr_r + ptr_one_lp;
            end
            if (send) begin
                rd_ptr_r <= rd_ptr_r + ptr_one_lp;
            end
        end
    end

    // Occupancy counter distinguishes full from empty when pointers coincide
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            occ_r <= '0;
        end else begin
            unique case ({enq, send})
                2'b10:   occ_r <= occ_r + occ_one_lp;
                2'b01:   occ_r <= occ_r - occ_one_lp;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Next credit count: send consumes, return restores, saturating at the grant
    always_comb begin
        avail_next = avail_r;
        if (send && !credit_return_i) begin
            avail_next = avail_r - cred_one_lp;
        end else if (!send && credit_return_i && (avail_r != cred_max_lp)) begin
            avail_next = avail_r + cred_one_lp;
        end
    end

    // Credit counter register, restored to the full grant on reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            avail_r <= cred_max_lp;
        end else begin
            avail_r <= avail_next;
        end
    end

    // Protocol checks: no enqueue while not ready, no return beyond the grant
    a_enq_when_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        lce_req_v_i |-> lce_req_ready_then_o)
        else $warning("bp_lce_req_buffer: lce_req_v_i while not ready, message dropped");

    a_credit_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        credit_return_i |-> (avail_r != cred_max_lp))
        else $warning("bp_lce_req_buffer: credit return with all credits held, count saturated");

endmodule

// File: tb/tb_bp_lce_req_buffer.sv
// Testbench for bp_lce_req_buffer: one instance with 8 credits (a_*) and one
// with 2 credits (b_*). Sent messages are checked against per-instance
// scoreboard queues filled when messages are enqueued.

module tb_bp_lce_req_buffer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    // Instance A: credits_p = 8
    logic [15:0] a_req_i = '0;
    logic        a_v_i = 1'b0;
    logic        a_ready;
    logic [15:0] a_req_o;
    logic        a_v_o;
    logic        a_ret = 1'b0;
    logic        a_full;
    logic        a_empty;
    logic [3:0]  a_avail;
    logic [1:0]  a_occ;

    // Instance B: credits_p = 2
    logic [15:0] b_req_i = '0;
    logic        b_v_i = 1'b0;
    logic        b_ready;
    logic [15:0] b_req_o;
    logic        b_v_o;
    logic        b_ret = 1'b0;
    logic        b_full;
    logic        b_empty;
    logic [1:0]  b_avail;
    logic [1:0]  b_occ;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] exp_d;

    int errors = 0;
    int checks = 0;

    bp_lce_req_buffer #(.msg_width_p(16), .els_p(2), .credits_p(8)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n),
        .lce_req_i(a_req_i), .lce_req_v_i(a_v_i), .lce_req_ready_then_o(a_ready),
        .lce_req_o(a_req_o), .lce_req_v_o(a_v_o), .credit_return_i(a_ret),
        .credits_full_o(a_full), .credits_empty_o(a_empty),
        .credit_avail_o(a_avail), .occupancy_o(a_occ)
    );

    bp_lce_req_buffer #(.msg_width_p(16), .els_p(2), .credits_p(2)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n),
        .lce_req_i(b_req_i), .lce_req_v_i(b_v_i), .lce_req_ready_then_o(b_ready),
        .lce_req_o(b_req_o), .lce_req_v_o(b_v_o), .credit_return_i(b_ret),
        .credits_full_o(b_full), .credits_empty_o(b_empty),
        .credit_avail_o(b_avail), .occupancy_o(b_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL reset_a_occ: got %0d want 0", a_occ); end
        checks++; if (a_avail !== 4'd8) begin errors++; $display("FAIL reset_a_avail: got %0d want 8", a_avail); end
        checks++; if (a_v_o !== 1'b0) begin errors++; $display("FAIL reset_a_v_o: got %b want 0", a_v_o); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b want 1", a_ready); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_a_full: got %b want 0", a_full); end
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_a_empty: got %b want 1", a_empty); end
        checks++; if (b_avail !== 2'd2) begin errors++; $display("FAIL reset_b_avail: got %0d want 2", b_avail); end
        checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL reset_b_empty: got %b want 1", b_empty); end
        tick();
        checks++; if (a_v_o !== 1'b0) begin errors++; $display("FAIL reset_idle_v_o: got %b want 0", a_v_o); end
    endtask

    task automatic test_latency_order();
        a_v_i = 1'b1; a_req_i = 16'h0011; qa.push_back(16'h0011);
        tick();
        checks++; if (a_v_o !== 1'b1) begin errors++; $display("FAIL lat_v_o_1: got %b want 1", a_v_o); end
        exp_d = (qa.size() != 0) ? qa[0] : 'x;
        checks++; if (a_req_o !== exp_d) begin errors++; $display("FAIL lat_data_1: got %h want %h", a_req_o, exp_d); end
        if (qa.size() != 0) void'(qa.pop_front());
        checks++; if (a_avail !== 4'd8) begin errors++; $display("FAIL lat_avail_8: got %0d want 8", a_avail); end
        a_req_i = 16'h0022; qa.push_back(16'h0022);
        tick();
        a_v_i = 1'b0;
        checks++; if (a_v_o !== 1'b1) begin errors++; $display("FAIL lat_v_o_2: got %b want 1", a_v_o); end
        exp_d = (qa.size() != 0) ? qa[0] : 'x;
        checks++; if (a_req_o !== exp_d) begin errors++; $display("FAIL lat_data_2: got %h want %h", a_req_o, exp_d); end
        if (qa.size() != 0) void'(qa.pop_front());
        checks++; if (a_avail !== 4'd7) begin errors++; $display("FAIL lat_avail_7: got %0d want 7", a_avail); end
        tick();
        checks++; if (a_v_o !== 1'b0) begin errors++; $display("FAIL lat_idle_v_o: got %b want 0", a_v_o); end
        checks++; if (a_avail !== 4'd6) begin errors++; $display("FAIL lat_avail_6: got %0d want 6", a_avail); end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL lat_occ: got %0d want 0", a_occ); end
    endtask

    task automatic test_reset_mid_traffic();
        a_v_i = 1'b1; a_req_i = 16'h0033;
        tick();
        a_req_i = 16'h0044;
        tick();
        a_v_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL rst_mid_occ: got %0d want 0", a_occ); end
        checks++; if (a_avail !== 4'd8) begin errors++; $display("FAIL rst_mid_avail: got %0d want 8", a_avail); end
        checks++; if (a_v_o !== 1'b0) begin errors++; $display("FAIL rst_mid_v_o: got %b want 0", a_v_o); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", a_ready); end
        tick();
        checks++; if (a_v_o !== 1'b0) begin errors++; $display("FAIL rst_hold_v_o: got %b want 0", a_v_o); end
        reset_n = 1'b1;
        qa.delete();
        qb.delete();
        tick();
        checks++; if (a_v_o !== 1'b0) begin errors++; $display("FAIL rst_after_v_o: got %b want 0", a_v_o); end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL rst_after_occ: got %0d want 0", a_occ); end
    endtask

    task automatic test_credit_exhaustion();
        int sends = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL exh_ready_%0d: got %b want 1", i, b_ready); end
            b_v_i = 1'b1; b_req_i = 16'h0100 + 16'(i); qb.push_back(16'h0100 + 16'(i));
            tick();
            if (b_v_o === 1'b1) begin
                sends++;
                exp_d = (qb.size() != 0) ? qb[0] : 'x;
                checks++; if (b_req_o !== exp_d) begin errors++; $display("FAIL exh_data_%0d: got %h want %h", i, b_req_o, exp_d); end
                if (qb.size() != 0) void'(qb.pop_front());
            end
        end
        b_v_i = 1'b0;
        checks++; if (sends != 2) begin errors++; $display("FAIL exh_sends: got %0d want 2", sends); end
        checks++; if (b_full !== 1'b1) begin errors++; $display("FAIL exh_full: got %b want 1", b_full); end
        checks++; if (b_occ !== 2'd2) begin errors++; $display("FAIL exh_occ: got %0d want 2", b_occ); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL exh_ready_full: got %b want 0", b_ready); end
        checks++; if (b_v_o !== 1'b0) begin errors++; $display("FAIL exh_v_o: got %b want 0", b_v_o); end
        b_ret = 1'b1;
        tick();
        b_ret = 1'b0;
        checks++; if (b_v_o !== 1'b1) begin errors++; $display("FAIL exh_ret_v_o: got %b want 1", b_v_o); end
        checks++; if (b_avail !== 2'd1) begin errors++; $display("FAIL exh_ret_avail: got %0d want 1", b_avail); end
        exp_d = (qb.size() != 0) ? qb[0] : 'x;
        checks++; if (b_req_o !== exp_d) begin errors++; $display("FAIL exh_ret_data: got %h want %h", b_req_o, exp_d); end
        if (qb.size() != 0) void'(qb.pop_front());
        tick();
        checks++; if (b_v_o !== 1'b0) begin errors++; $display("FAIL exh_one_send: got %b want 0", b_v_o); end
        checks++; if (b_occ !== 2'd1) begin errors++; $display("FAIL exh_occ_1: got %0d want 1", b_occ); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL exh_ready_back: got %b want 1", b_ready); end
        // Drain the last message and restore both credits
        b_ret = 1'b1;
        tick();
        exp_d = (qb.size() != 0) ? qb[0] : 'x;
        checks++; if (b_v_o !== 1'b1 || b_req_o !== exp_d) begin errors++; $display("FAIL exh_drain: got v=%b %h want v=1 %h", b_v_o, b_req_o, exp_d); end
        if (qb.size() != 0) void'(qb.pop_front());
        tick();
        checks++; if (b_avail !== 2'd1) begin errors++; $display("FAIL exh_send_ret_avail: got %0d want 1", b_avail); end
        tick();
        b_ret = 1'b0;
        checks++; if (b_empty !== 1'b1 || b_avail !== 2'd2) begin errors++; $display("FAIL exh_restored: got empty=%b avail=%0d want 1/2", b_empty, b_avail); end
    endtask

    task automatic test_simultaneous_return();
        for (int i = 0; i < 6; i++) begin
            a_v_i = 1'b1; a_req_i = 16'h0050 + 16'(i); qa.push_back(16'h0050 + 16'(i));
            tick();
            exp_d = (qa.size() != 0) ? qa[0] : 'x;
            checks++; if (a_v_o !== 1'b1 || a_req_o !== exp_d) begin errors++; $display("FAIL sim_stream_%0d: got v=%b %h want v=1 %h", i, a_v_o, a_req_o, exp_d); end
            if (qa.size() != 0) void'(qa.pop_front());
        end
        a_v_i = 1'b0;
        checks++; if (a_avail !== 4'd3) begin errors++; $display("FAIL sim_avail_pre: got %0d want 3", a_avail); end
        a_ret = 1'b1;
        tick();
        a_ret = 1'b0;
        checks++; if (a_avail !== 4'd3) begin errors++; $display("FAIL sim_avail_post: got %0d want 3", a_avail); end
        checks++; if (a_occ !== 2'd0 || a_v_o !== 1'b0) begin errors++; $display("FAIL sim_drained: got occ=%0d v=%b want 0/0", a_occ, a_v_o); end
        a_ret = 1'b1;
        repeat (5) tick();
        a_ret = 1'b0;
        checks++; if (a_avail !== 4'd8 || a_empty !== 1'b1) begin errors++; $display("FAIL sim_restored: got avail=%0d empty=%b want 8/1", a_avail, a_empty); end
    endtask

    task automatic test_full_drain();
        for (int i = 0; i < 4; i++) begin
            b_v_i = 1'b1; b_req_i = 16'h0200 + 16'(i); qb.push_back(16'h0200 + 16'(i));
            tick();
            if (b_v_o === 1'b1) begin
                exp_d = (qb.size() != 0) ? qb[0] : 'x;
                checks++; if (b_req_o !== exp_d) begin errors++; $display("FAIL full_fill_%0d: got %h want %h", i, b_req_o, exp_d); end
                if (qb.size() != 0) void'(qb.pop_front());
            end
        end
        b_v_i = 1'b0;
        b_ret = 1'b1;
        tick();
        b_ret = 1'b0;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", b_ready); end
        checks++; if (b_occ !== 2'd2) begin errors++; $display("FAIL full_occ: got %0d want 2", b_occ); end
        exp_d = (qb.size() != 0) ? qb[0] : 'x;
        checks++; if (b_v_o !== 1'b1 || b_req_o !== exp_d) begin errors++; $display("FAIL full_send: got v=%b %h want v=1 %h", b_v_o, b_req_o, exp_d); end
        if (qb.size() != 0) void'(qb.pop_front());
        tick();
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL full_ready_next: got %b want 1", b_ready); end
        checks++; if (b_occ !== 2'd1 || b_avail !== 2'd0) begin errors++; $display("FAIL full_after: got occ=%0d avail=%0d want 1/0", b_occ, b_avail); end
    endtask

    task automatic test_errors();
        // Credit return with the full grant held saturates
        a_ret = 1'b1;
        tick();
        a_ret = 1'b0;
        checks++; if (a_avail !== 4'd8 || a_empty !== 1'b1) begin errors++; $display("FAIL err_overflow: got avail=%0d empty=%b want 8/1", a_avail, a_empty); end
        // Fill instance B, then offer a message while not ready
        b_v_i = 1'b1; b_req_i = 16'h0300; qb.push_back(16'h0300);
        tick();
        b_v_i = 1'b1; b_req_i = 16'h0EEE;
        tick();
        b_v_i = 1'b0;
        checks++; if (b_occ !== 2'd2 || b_ready !== 1'b0) begin errors++; $display("FAIL err_dropped: got occ=%0d ready=%b want 2/0", b_occ, b_ready); end
        b_ret = 1'b1;
        tick();
        exp_d = (qb.size() != 0) ? qb[0] : 'x;
        checks++; if (b_v_o !== 1'b1 || b_req_o !== exp_d) begin errors++; $display("FAIL err_drain_1: got v=%b %h want v=1 %h", b_v_o, b_req_o, exp_d); end
        if (qb.size() != 0) void'(qb.pop_front());
        tick();
        exp_d = (qb.size() != 0) ? qb[0] : 'x;
        checks++; if (b_v_o !== 1'b1 || b_req_o !== exp_d) begin errors++; $display("FAIL err_drain_2: got v=%b %h want v=1 %h", b_v_o, b_req_o, exp_d); end
        if (qb.size() != 0) void'(qb.pop_front());
        tick();
        b_ret = 1'b0;
        checks++; if (b_occ !== 2'd0 || b_v_o !== 1'b0 || b_avail !== 2'd1) begin errors++; $display("FAIL err_empty: got occ=%0d v=%b avail=%0d want 0/0/1", b_occ, b_v_o, b_avail); end
    endtask

    initial begin
        test_reset();
        test_latency_order();
        test_reset_mid_traffic();
        test_credit_exhaustion();
        test_simultaneous_return();
        test_full_drain();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_lce_req_buffer.md
Name: bp_lce_req_buffer

Overview:
Elastic buffer plus credit-based flow controller on the egress side of the LCE request path. It accepts LCE request messages on a ready-then-valid port and holds them in a small FIFO. It launches them onto the coherence NoC request link only when a NoC credit is available, and recovers credits from credit-return pulses. It also exports credit occupancy status, which the LCE's cache-facing busy logic consumes.

Parameters:
msg_width_p, 128, width in bits of one LCE request message (set to lce_req_msg_width_lp at instantiation)
els_p, 2, FIFO depth in messages; power of two, >= 2
credits_p, 8, NoC credits granted to this LCE at reset; >= 1

Ports:
clk_i  input  1  clock; all state updates on the rising edge
reset_n_i  input  1  asynchronous, active-low reset
lce_req_i  input  msg_width_p  request message from the LCE
lce_req_v_i  input  1  message valid; legal only in a cycle where lce_req_ready_then_o=1
lce_req_ready_then_o  output  1  buffer can accept a message this cycle
lce_req_o  output  msg_width_p  message at the FIFO head, driven to the NoC
lce_req_v_o  output  1  send pulse; the NoC always accepts (credit-guaranteed)
credit_return_i  input  1  one credit returned by the NoC this cycle
credits_full_o  output  1  all credits in use (available == 0)
credits_empty_o  output  1  no credits outstanding (available == credits_p)
credit_avail_o  output  clog2(credits_p+1)  available credit count
occupancy_o  output  clog2(els_p+1)  current FIFO occupancy

Behaviour:
- Reset (reset_n_i low, asynchronous): FIFO emptied, pointers = 0, occupancy_o = 0.
  - Credit counter = credits_p.
  - Outputs: lce_req_v_o = 0, lce_req_ready_then_o = 1, credits_full_o = 0, credits_empty_o = 1, credit_avail_o = credits_p.
  - lce_req_o content is don't-care.
- Reset asserted mid-operation: all buffered messages are discarded and credits are restored to credits_p. No send pulse may appear in or after the reset cycle until a message is re-enqueued.
- Enqueue: enq = lce_req_v_i & lce_req_ready_then_o.
  - lce_req_ready_then_o = (occupancy < els_p). It depends only on registered state, never on a same-cycle dequeue.
  - lce_req_v_i asserted while ready_then_o = 0 is a protocol error. The simulation assertion fires, and the message is dropped with no state change.
- Dequeue/send: lce_req_v_o = (occupancy > 0) & (credit_avail > 0). This is a combinational function of registered state only.
  - A send pops the head and consumes one credit in the same edge.
- Latency: no bypass. A message enqueued in cycle N is visible on lce_req_o no earlier than N+1; with credits available, it sends in N+1.
- Order: strict FIFO; messages leave in arrival order.
- Pointers wrap modulo els_p. The full/empty distinction is carried by the occupancy counter.
- Simultaneous enq and send: occupancy unchanged, both pointers advance. This is legal at full occupancy only if enq was permitted, which it is not, because ready_then_o is 0 when full.
- Credit counter: next = avail - send + credit_return_i.
  - Simultaneous send and return: count unchanged.
  - Return when avail == credits_p is an overflow error. The assertion fires and the count saturates at credits_p.
  - With avail == 0 and credit_return_i = 1: a send is not possible that cycle (v_o = 0); next = 1 and the send occurs the following cycle.
- Status outputs are combinational decodes of the registered counter: credits_full_o = (avail == 0), credits_empty_o = (avail == credits_p).
- Counter widths: occupancy clog2(els_p+1) bits; credits clog2(credits_p+1) bits. No arithmetic may wrap.

Test Plan:
1. Reset mid-traffic: enqueue 2 messages, then pulse reset_n_i low for 1 cycle. Required: occupancy_o = 0, credit_avail_o = 8, lce_req_v_o = 0 immediately (asynchronous), ready_then_o = 1.
2. Latency/order: enqueue A=0x11, B=0x22 in consecutive cycles (cycles 0, 1) with 8 credits. Required: lce_req_v_o high in cycles 1 and 2 with data 0x11 then 0x22; credit_avail_o goes 8 -> 7 -> 6.
3. Credit exhaustion: credits_p=2, no returns, enqueue 4 messages back-to-back.
   - Required: 2 sends, credits_full_o = 1, occupancy_o = 2, ready_then_o = 0.
   - One credit_return_i pulse: exactly one send the next cycle, then ready_then_o = 1.
4. Simultaneous return+send: avail = 3 with a message queued; assert credit_return_i in the send cycle. Required: avail stays 3.
5. Full with concurrent drain: FIFO full (2), credits available, lce_req_v_i held low. Required: ready_then_o = 0 this cycle, 1 next cycle after one send. No enqueue is accepted during the full cycle.
6. Error checks:
   - Return with avail = credits_p -> assertion fires, avail stays credits_p.
   - v_i while ready_then_o = 0 -> assertion fires, occupancy unchanged.
